// File: rtl/controle_divisor.sv
// Shared halving-unit controller: arbitrates two requesters and computes
// floor(A / 2^n) by passing an accumulator through divisor8Bits once per clock.

module divisor8Bits (
    input  logic [7:0] A,
    output logic [6:0] A_div
);
    assign A_div = A[7:1];
endmodule

module controle_divisor (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] a0,
    input  logic [2:0] n0,
    input  logic       req1,
    input  logic [7:0] a1,
    input  logic [2:0] n1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       done,
    output logic       owner,
    output logic [7:0] result
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [2:0] cnt_q, cnt_d;
    logic       win_q, win_d;
    logic       prio_q, prio_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       done_q, done_d;
    logic       owner_q, owner_d;
    logic [7:0] result_q, result_d;

    logic [6:0] half;
    logic       sel;

    divisor8Bits u_div (
        .A     (acc_q),
        .A_div (half)
    );

    // Contention goes to the round-robin pointer; otherwise the lone requester wins.
    assign sel = (req0 && req1) ? prio_q : req1;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        prio_d   = prio_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done_d   = 1'b0;
        owner_d  = owner_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    acc_d  = sel ? a1 : a0;
                    cnt_d  = sel ? n1 : n0;
                    win_d  = sel;
                    gnt0_d = ~sel;
                    gnt1_d = sel;
                    prio_d = ~sel;
                    if (cnt_d == 3'd0) begin
                        state_d  = DONE;
                        result_d = acc_d;
                        owner_d  = sel;
                        done_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = {1'b0, half};
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d  = DONE;
                    result_d = {1'b0, half};
                    owner_d  = win_q;
                    done_d   = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            win_q    <= 1'b0;
            prio_q   <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done_q   <= 1'b0;
            owner_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            prio_q   <= prio_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done_q   <= done_d;
            owner_q  <= owner_d;
            result_q <= result_d;
        end
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign owner  = owner_q;
    assign result = result_q;
endmodule

// File: tb/tb_controle_divisor.sv
// Scoreboard bench for controle_divisor: stimulus queues hand-computed results,
// a negedge monitor checks each done pulse (owner, result, latency from grant).

module tb_controle_divisor;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] a0 = '0, a1 = '0;
    logic [2:0] n0 = '0, n1 = '0;
    logic       gnt0, gnt1, busy, done, owner;
    logic [7:0] result;

    controle_divisor dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .n0(n0),
        .req1(req1), .a1(a1), .n1(n1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .done(done), .owner(owner), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       own;
        logic [7:0] res;
        int         n;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   gnt_cyc = 0;
    int   gnt_cnt = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;
    bit   sim_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: grant bookkeeping plus scoreboard comparison on every done.
    initial begin
        exp_t e;
        while (!sim_done) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                gnt_cnt++;
                gnt_cyc = cyc;
                check("gnt_exclusive", int'(gnt0 && gnt1), 0);
                check("busy_at_gnt", int'(busy), 1);
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("owner", int'(owner), int'(e.own));
                    check("result", int'(result), int'(e.res));
                    check("latency", cyc - gnt_cyc, e.n);
                end
            end
        end
    end

    task automatic wait_gnt(input int idx);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((idx == 0 && gnt0) || (idx == 1 && gnt1)) return;
        end
        check("gnt_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check("idle_timeout", 0, 1);
    endtask

    task automatic run_op(input int idx, input logic [7:0] a, input logic [2:0] n,
                          input logic [7:0] exp_res);
        int k;
        exp_t e;
        e.own = idx[0]; e.res = exp_res; e.n = int'(n);
        exp_q.push_back(e);
        if (idx == 0) begin a0 = a; n0 = n; req0 = 1'b1; end
        else          begin a1 = a; n1 = n; req1 = 1'b1; end
        wait_gnt(idx);
        req0 = 1'b0; req1 = 1'b0;
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("busy_len", k, int'(n) + 1);
    endtask

    initial begin
        exp_t e;
        int g0;
        int d0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_gnt", int'(gnt0 | gnt1), 0);
        check("rst_owner", int'(owner), 0);
        check("rst_result", int'(result), 0);
        reset = 1'b0;
        @(negedge clk);

        run_op(0, 8'd200, 3'd3, 8'd25);
        run_op(1, 8'hFF, 3'd0, 8'd255);
        run_op(0, 8'hFF, 3'd7, 8'd1);
        run_op(0, 8'h7F, 3'd7, 8'd0);

        // req1 arrives while requester 0 is being served
        e.own = 1'b0; e.res = 8'd8;  e.n = 4; exp_q.push_back(e);
        e.own = 1'b1; e.res = 8'd16; e.n = 2; exp_q.push_back(e);
        a0 = 8'h80; n0 = 3'd4; req0 = 1'b1;
        wait_gnt(0);
        req0 = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        a1 = 8'h40; n1 = 3'd2; req1 = 1'b1;
        wait_gnt(1);
        req1 = 1'b0;
        check("gnt1_after_done", done_cnt - d0, 1);
        check("gnt1_gap", cyc - last_done_cyc, 2);
        check("result_held", int'(result), 8);
        wait_idle();

        // Reset two cycles into an n=5 run
        e.own = 1'b0; e.res = 8'd6; e.n = 5; exp_q.push_back(e);
        a0 = 8'hC8; n0 = 3'd5; req0 = 1'b1;
        wait_gnt(0);
        req0 = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_result", int'(result), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Both requesters held: owners alternate starting at 0
        for (int i = 0; i < 2; i++) begin
            e.own = 1'b0; e.res = 8'd50; e.n = 1; exp_q.push_back(e);
            e.own = 1'b1; e.res = 8'd15; e.n = 2; exp_q.push_back(e);
        end
        a0 = 8'd100; n0 = 3'd1; a1 = 8'd60; n1 = 3'd2;
        g0 = gnt_cnt;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 100 && gnt_cnt < g0 + 4; i++) @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        check("rr_grants", gnt_cnt - g0, 4);
        wait_idle();

        run_op(0, 8'd150, 3'd5, 8'd4);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        sim_done = 1'b1;
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
